// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC I/O host: FSM state encoding, cycle-type
// nibbles and the SYNC codes a peripheral can return.
package lpc_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_START,
    ST_CYCDIR,
    ST_ADDR1,
    ST_ADDR2,
    ST_ADDR3,
    ST_ADDR4,
    ST_WDATA1,
    ST_WDATA2,
    ST_TAR1,
    ST_TAR2,
    ST_SYNC,
    ST_RDATA1,
    ST_RDATA2,
    ST_TAREND1,
    ST_TAREND2,
    ST_ABORT,
    ST_ABORT_END
  } lpc_state_t;

  localparam logic [3:0] LPC_START       = 4'b0000;
  localparam logic [3:0] AD_IDLE         = 4'b1111;

  localparam logic [3:0] CYC_IO_READ     = 4'b0000;
  localparam logic [3:0] CYC_IO_WRITE    = 4'b0010;

  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;

endpackage

// File: rtl/lpc_host_sync.sv
// SYNC phase decoder: classifies the sampled LAD nibble and owns the wait counter.
// The counter clears whenever the host is outside SYNC; the limit widens for good once long-wait is seen.
module lpc_host_sync
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT      = 8,
  parameter int LONG_WAIT_TIMEOUT = 255
) (
  input  logic       lpc_clock,
  input  logic       lpc_reset,
  input  logic       sync_active,
  input  logic [3:0] lpc_ad_in,
  output logic       sync_ready,
  output logic       sync_error,
  output logic       sync_timeout
);

  localparam logic [7:0] SHORT_LIMIT = 8'(SYNC_TIMEOUT);
  localparam logic [7:0] LONG_LIMIT  = 8'(LONG_WAIT_TIMEOUT);

  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_inc;
  logic [7:0] limit;
  logic       long_wait_q;
  logic       long_wait_seen;

  always_comb begin
    sync_ready     = 1'b0;
    sync_error     = 1'b0;
    long_wait_seen = 1'b0;
    case (lpc_ad_in)
      SYNC_READY:      sync_ready = sync_active;
      SYNC_ERROR: begin
        sync_ready = sync_active;
        sync_error = sync_active;
      end
      SYNC_LONG_WAIT:  long_wait_seen = sync_active;
      SYNC_SHORT_WAIT: ;
      default:         ;
    endcase
    // A long-wait in this very clock already applies the wider limit.
    limit        = (long_wait_q || long_wait_seen) ? LONG_LIMIT : SHORT_LIMIT;
    wait_cnt_inc = wait_cnt + 8'd1;
    sync_timeout = sync_active && !sync_ready && (wait_cnt_inc >= limit);
  end

  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset || !sync_active) begin
      wait_cnt    <= '0;
      long_wait_q <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_inc;
      if (long_wait_seen) long_wait_q <= 1'b1;
    end
  end

endmodule

// File: rtl/lpc_host.sv
// LPC I/O read/write host; one request in flight, req_ready only in IDLE, one-clock rsp_valid pulse.
// Define LPC_HOST_ABORT_EN to drive a 4-clock LFRAME# abort on SYNC timeout.
module lpc_host
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT      = 8,
  parameter int LONG_WAIT_TIMEOUT = 255
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in
);

  lpc_state_t  state_q, state_d;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        err_q;

  logic        req_ready_d, rsp_valid_d, rsp_error_d, rsp_timeout_d;
  logic [7:0]  rsp_rdata_d;
  logic        frame_d, ad_oe_d;
  logic [3:0]  ad_out_d;

  logic        sync_ready, sync_error, sync_timeout;

  lpc_host_sync #(
    .SYNC_TIMEOUT      (SYNC_TIMEOUT),
    .LONG_WAIT_TIMEOUT (LONG_WAIT_TIMEOUT)
  ) u_sync (
    .lpc_clock    (lpc_clock),
    .lpc_reset    (lpc_reset),
    .sync_active  (state_q == ST_SYNC),
    .lpc_ad_in    (lpc_ad_in),
    .sync_ready   (sync_ready),
    .sync_error   (sync_error),
    .sync_timeout (sync_timeout)
  );

`ifdef LPC_HOST_ABORT_EN
  logic [1:0] abort_cnt;

  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset || state_q != ST_ABORT) abort_cnt <= '0;
    else                                   abort_cnt <= abort_cnt + 2'd1;
  end
`endif

  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = 1'b0;
    rsp_error_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = '0;
    case (state_q)
      ST_IDLE:    if (req_valid && req_ready) state_d = ST_START;
      ST_START:   state_d = ST_CYCDIR;
      ST_CYCDIR:  state_d = ST_ADDR1;
      ST_ADDR1:   state_d = ST_ADDR2;
      ST_ADDR2:   state_d = ST_ADDR3;
      ST_ADDR3:   state_d = ST_ADDR4;
      ST_ADDR4:   state_d = wr_q ? ST_WDATA1 : ST_TAR1;
      ST_WDATA1:  state_d = ST_WDATA2;
      ST_WDATA2:  state_d = ST_TAR1;
      ST_TAR1:    state_d = ST_TAR2;
      ST_TAR2:    state_d = ST_SYNC;
      ST_SYNC: begin
        if (sync_ready) begin
          state_d = wr_q ? ST_TAREND1 : ST_RDATA1;
        end else if (sync_timeout) begin
`ifdef LPC_HOST_ABORT_EN
          state_d = ST_ABORT;
`else
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
`endif
        end
      end
      ST_RDATA1:  state_d = ST_RDATA2;
      ST_RDATA2:  state_d = ST_TAREND1;
      ST_TAREND1: state_d = ST_TAREND2;
      ST_TAREND2: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_error_d = err_q;
        rsp_rdata_d = wr_q ? 8'h00 : rdata_q;
      end
`ifdef LPC_HOST_ABORT_EN
      ST_ABORT:   if (abort_cnt == 2'd3) state_d = ST_ABORT_END;
      ST_ABORT_END: begin
        state_d       = ST_IDLE;
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = 1'b1;
      end
`endif
      default:    state_d = ST_IDLE;
    endcase

    frame_d  = 1'b1;
    ad_out_d = AD_IDLE;
    ad_oe_d  = 1'b0;
    case (state_d)
      ST_START: begin
        frame_d  = 1'b0;
        ad_out_d = LPC_START;
        ad_oe_d  = 1'b1;
      end
      ST_CYCDIR: begin
        ad_out_d = wr_q ? CYC_IO_WRITE : CYC_IO_READ;
        ad_oe_d  = 1'b1;
      end
      ST_ADDR1:  begin ad_out_d = addr_q[15:12]; ad_oe_d = 1'b1; end
      ST_ADDR2:  begin ad_out_d = addr_q[11:8];  ad_oe_d = 1'b1; end
      ST_ADDR3:  begin ad_out_d = addr_q[7:4];   ad_oe_d = 1'b1; end
      ST_ADDR4:  begin ad_out_d = addr_q[3:0];   ad_oe_d = 1'b1; end
      ST_WDATA1: begin ad_out_d = wdata_q[3:0];  ad_oe_d = 1'b1; end
      ST_WDATA2: begin ad_out_d = wdata_q[7:4];  ad_oe_d = 1'b1; end
      ST_TAR1:   ad_oe_d = 1'b1;
`ifdef LPC_HOST_ABORT_EN
      ST_ABORT: begin
        frame_d = 1'b0;
        ad_oe_d = 1'b1;
      end
`endif
      default:   ;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      lpc_frame   <= 1'b1;
      lpc_ad_out  <= AD_IDLE;
      lpc_ad_oe   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_error   <= rsp_error_d;
      rsp_timeout <= rsp_timeout_d;
      lpc_frame   <= frame_d;
      lpc_ad_out  <= ad_out_d;
      lpc_ad_oe   <= ad_oe_d;
      if (state_q == ST_IDLE && req_valid && req_ready) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == ST_SYNC && sync_ready) err_q <= sync_error;
      if (state_q == ST_RDATA1) rdata_q[3:0] <= lpc_ad_in;
      if (state_q == ST_RDATA2) rdata_q[7:4] <= lpc_ad_in;
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: a bus-level peripheral script per transaction plus a response scoreboard.
// Latency is counted as clock edges strictly between the accepting edge and the edge that raises rsp_valid.
module tb_lpc_host;
  import lpc_pkg::*;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_error, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic        lpc_frame, lpc_ad_oe;
  logic [3:0]  lpc_ad_out, lpc_ad_in;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0]  rdata;
    logic        err;
    logic        tmo;
    logic [15:0] lat;
  } rsp_t;

  rsp_t sb[$];

  lpc_host dut (
    .lpc_clock   (lpc_clock),
    .lpc_reset   (lpc_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .lpc_frame   (lpc_frame),
    .lpc_ad_out  (lpc_ad_out),
    .lpc_ad_oe   (lpc_ad_oe),
    .lpc_ad_in   (lpc_ad_in)
  );

  always #5 lpc_clock = ~lpc_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {frame, oe, ad} for header cycle c (1 = START) up to TAR1.
  function automatic logic [5:0] hdr_exp(input int c, input logic wr, input logic [15:0] a,
                                         input logic [7:0] d);
    logic [5:0] r;
    r = {2'b11, 4'hF};
    case (c)
      1: r = {2'b01, 4'h0};
      2: r = {2'b11, wr ? 4'h2 : 4'h0};
      3: r = {2'b11, a[15:12]};
      4: r = {2'b11, a[11:8]};
      5: r = {2'b11, a[7:4]};
      6: r = {2'b11, a[3:0]};
      7: r = wr ? {2'b11, d[3:0]} : {2'b11, 4'hF};
      8: r = {2'b11, d[7:4]};
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_txn(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [7:0] wd, input int n_wait, input logic [3:0] wait_code,
                         input logic [3:0] end_code, input logic [7:0] rd, input bit tmo);
    int   s, rsp_c, ab_lo, ab_hi;
    bit   done;
    rsp_t e, got;
    s     = wr ? 11 : 9;
    ab_lo = 0;
    ab_hi = -1;
    if (tmo) begin
`ifdef LPC_HOST_ABORT_EN
      ab_lo = s + 8;
      ab_hi = s + 11;
      rsp_c = s + 13;
`else
      rsp_c = s + 8;
`endif
      e = '{rdata: 8'h00, err: 1'b0, tmo: 1'b1, lat: 16'(rsp_c - 2)};
    end else begin
      rsp_c = s + n_wait + (wr ? 3 : 5);
      e = '{rdata: wr ? 8'h00 : rd, err: (end_code == SYNC_ERROR), tmo: 1'b0,
            lat: 16'(rsp_c - 2)};
    end
    sb.push_back(e);

    @(negedge lpc_clock);
    check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge lpc_clock);
    done = 1'b0;
    for (int c = 1; c <= 400 && !done; c++) begin
      @(negedge lpc_clock);
      if (c == 1) begin
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~addr;
        req_wdata = ~wd;
        check({tag, " ready_busy"}, 32'(req_ready), 32'd0);
      end
      if (c < s)                         lpc_ad_in = 4'hF;
      else if (tmo || c < s + n_wait)    lpc_ad_in = wait_code;
      else if (c == s + n_wait)          lpc_ad_in = end_code;
      else if (!wr && c == s + n_wait + 1) lpc_ad_in = rd[3:0];
      else if (!wr && c == s + n_wait + 2) lpc_ad_in = rd[7:4];
      else                               lpc_ad_in = 4'hF;

      if (rsp_valid) begin
        done = 1'b1;
        check({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          e   = sb.pop_front();
          got = '{rdata: rsp_rdata, err: rsp_error, tmo: rsp_timeout, lat: 16'(c - 2)};
          check({tag, " rdata"}, 32'(got.rdata), 32'(e.rdata));
          check({tag, " error"}, 32'(got.err), 32'(e.err));
          check({tag, " timeout"}, 32'(got.tmo), 32'(e.tmo));
          check({tag, " latency"}, 32'(got.lat), 32'(e.lat));
          check({tag, " ready_done"}, 32'(req_ready), 32'd1);
        end
      end else if (c >= ab_lo && c <= ab_hi) begin
        check($sformatf("%s abort c%0d", tag, c), 32'({lpc_frame, lpc_ad_oe, lpc_ad_out}),
              32'({2'b01, 4'hF}));
      end else if (c <= s - 2) begin
        check($sformatf("%s hdr c%0d", tag, c), 32'({lpc_frame, lpc_ad_oe, lpc_ad_out}),
              32'(hdr_exp(c, wr, addr, wd)));
      end else begin
        check($sformatf("%s bus c%0d", tag, c), 32'({lpc_frame, lpc_ad_oe}), 32'(2'b10));
      end
    end
    if (!done) check({tag, " rsp_seen"}, 32'(done), 32'd1);
    @(negedge lpc_clock);
    check({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    lpc_ad_in = 4'hF;
  endtask

  initial begin
    int pulses;
    lpc_reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    lpc_ad_in = 4'hF;

    repeat (3) @(negedge lpc_clock);
    check("reset_outputs",
          32'({req_ready, rsp_valid, rsp_error, rsp_timeout, lpc_frame, lpc_ad_oe, lpc_ad_out, rsp_rdata}),
          32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 8'h00}));
    lpc_reset = 1'b1;
    @(negedge lpc_clock);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    run_txn("wr80", 1'b1, 16'h0080, 8'h5A, 0, 4'hF, SYNC_READY, 8'h00, 1'b0);
    run_txn("rd2E", 1'b0, 16'h002E, 8'h00, 3, SYNC_SHORT_WAIT, SYNC_READY, 8'hC3, 1'b0);
    run_txn("rd60_tmo", 1'b0, 16'h0060, 8'h00, 0, 4'hF, SYNC_READY, 8'h00, 1'b1);
    run_txn("rd_long", 1'b0, 16'h1234, 8'h00, 100, SYNC_LONG_WAIT, SYNC_READY, 8'h5E, 1'b0);
    run_txn("rd_err", 1'b0, 16'hABCD, 8'h00, 0, 4'hF, SYNC_ERROR, 8'hA7, 1'b0);
    run_txn("wr_edge", 1'b1, 16'hFFFF, 8'h00, 7, 4'hF, SYNC_READY, 8'h00, 1'b0);
    run_txn("wr_err", 1'b1, 16'h03F8, 8'h81, 2, SYNC_SHORT_WAIT, SYNC_ERROR, 8'h00, 1'b0);

    // Reset while ADDR2 is on the bus: the request is dropped silently.
    @(negedge lpc_clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0360;
    @(posedge lpc_clock);
    for (int c = 1; c <= 4; c++) begin
      @(negedge lpc_clock);
      if (c == 1) req_valid = 1'b0;
    end
    check("mid_addr2", 32'({lpc_frame, lpc_ad_oe, lpc_ad_out}), 32'({2'b11, 4'h3}));
    lpc_reset = 1'b0;
    @(negedge lpc_clock);
    check("mid_reset_bus", 32'({lpc_frame, lpc_ad_oe, lpc_ad_out}), 32'({2'b10, 4'hF}));
    check("mid_reset_rsp", 32'({req_ready, rsp_valid}), 32'd0);
    lpc_reset = 1'b1;
    @(negedge lpc_clock);
    check("mid_release_ready", 32'(req_ready), 32'd1);
    pulses = 0;
    repeat (16) begin
      @(negedge lpc_clock);
      if (rsp_valid) pulses++;
    end
    check("mid_no_rsp", 32'(pulses), 32'd0);

    run_txn("rd_after_rst", 1'b0, 16'h0060, 8'h00, 1, SYNC_SHORT_WAIT, SYNC_READY, 8'h42, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 SHALL have parameter SYNC_TIMEOUT, default 8, meaning max SYNC clocks without ready/long-wait before timeout.
REQ-002 SHALL have parameter LONG_WAIT_TIMEOUT, default 255, meaning max SYNC clocks once long-wait (0110) seen.
REQ-003 SHALL have ports:
- lpc_clock  in  1  single clock, all logic on rising edge.
- lpc_reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  host idle, request accepted when req_valid&&req_ready.
- req_write  in  1  1=I/O write, 0=I/O read.
- req_addr  in  16  I/O address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-clock completion pulse.
- rsp_rdata  out  8  read data, valid with rsp_valid.
- rsp_error  out  1  peripheral SYNC error (1010) seen.
- rsp_timeout  out  1  SYNC timeout.
- lpc_frame  out  1  LFRAME#, active low.
- lpc_ad_out  out  4  LAD drive value.
- lpc_ad_oe  out  1  LAD output enable.
- lpc_ad_in  in  4  LAD sampled value.

Function
REQ-004 SHALL register all outputs; a request is accepted only in IDLE; req_ready=1 only in IDLE, not in the acceptance cycle's successor.
REQ-005 SHALL latch req_write/addr/wdata on acceptance and ignore inputs until return to IDLE.
REQ-006 States, one clock each unless noted: IDLE -> START (frame=0, AD=0000) -> CYCDIR (frame=1, AD=0000 read / 0010 write) -> ADDR1..ADDR4 (addr[15:12],[11:8],[7:4],[3:0]).
REQ-007 Write: ADDR4 -> WDATA1 (wdata[3:0]) -> WDATA2 (wdata[7:4]) -> TAR1; read: ADDR4 -> TAR1.
REQ-008 TAR1 drives AD=1111 oe=1; TAR2 oe=0; then SYNC with oe=0.
REQ-009 SYNC samples lpc_ad_in each clock: 0000 ready; 1010 error (set rsp_error, proceed as ready); 0101 short wait; 0110 long wait (switch limit to LONG_WAIT_TIMEOUT); other values count as no response.
REQ-010 SYNC counter 8 bits, cleared on SYNC entry; timeout when count reaches active limit without ready/error; long-wait does not clear count.
REQ-011 Read after ready: RDATA1 samples rdata[3:0], RDATA2 samples rdata[7:4], then TAREND1, TAREND2 (oe=0 both); write after ready: TAREND1, TAREND2.
REQ-012 After TAREND2 SHALL enter IDLE and pulse rsp_valid with rsp_error/rsp_timeout status; rsp_rdata=0 for writes.
REQ-013 Latency with zero-wait ready: 12 clocks from acceptance to rsp_valid for both read and write.
REQ-014 lpc_ad_oe SHALL be 1 only in START..TAR1 (and ABORT when enabled); never 1 in SYNC/RDATA/TAREND.
REQ-015 Simultaneous ready and limit reached in same clock: ready wins.

Reset
REQ-016 lpc_reset low at any clock, including mid-cycle: next state IDLE, lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=1111, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0; in-flight request dropped with no response.
REQ-017 req_ready SHALL rise the first clock after lpc_reset deasserts.

Configuration
REQ-018 Macro LPC_HOST_ABORT_EN defined: on timeout, enter ABORT, drive frame=0, AD=1111, oe=1 for 4 clocks, then one clock frame=1 oe=0, then IDLE with rsp_valid, rsp_timeout=1.
REQ-019 Macro undefined: on timeout, go to IDLE next clock with rsp_valid, rsp_timeout=1; frame stays 1, oe stays 0.

Structure
REQ-020 Package lpc_pkg SHALL hold state enum, cycle-type codes (IO_READ=0000, IO_WRITE=0010) and SYNC codes (READY, SHORT_WAIT, LONG_WAIT, ERROR).
REQ-021 One sub-module lpc_host_sync SHALL decode SYNC and own the wait counter, reporting ready/error/timeout.

Verification
REQ-022 Write 0x80 <- 0x5A, peripheral SYNC 0000 immediately -> AD sequence 0000,0010,0,0,8,0,A,5,1111,Z; rsp_valid 12 clocks after accept.
REQ-023 Read 0x002E, SYNC 0101x3 then 0000, data nibbles 3,C -> rsp_rdata=0xC3, rsp_error=0, latency 15.
REQ-024 Read 0x0060, SYNC 1111 forever -> rsp_timeout=1 after 8 SYNC clocks; with LPC_HOST_ABORT_EN frame low exactly 4 clocks, AD=1111.
REQ-025 Read with SYNC 0110 for 100 clocks then 0000 -> completes, no timeout; SYNC 1010 -> rsp_error=1, data returned.
REQ-026 lpc_reset low during ADDR2 -> next clock frame=1, oe=0, no rsp_valid; new request after release completes normally.
